// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared encodings for the debug memory access engine
package dbg_pkg;

    typedef enum logic [1:0] {
        OP_PROBE_RD = 2'd0,
        OP_MEM_RD   = 2'd1,
        OP_MEM_WR   = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    localparam logic [1:0] TGT_IM = 2'd0;
    localparam logic [1:0] TGT_DM = 2'd1;
    localparam logic [1:0] TGT_RF = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_RD_REQ,
        S_RD_DATA,
        S_RSP,
        S_WR,
        S_ACK
    } state_e;

endpackage

// File: rtl/dbg_mem_access_if.sv
// rtl/dbg_mem_access_if.sv - command, write-data and response streams of the debug engine
interface dbg_mem_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [1:0]        cmd_tgt;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wdat_valid;
    logic              wdat_ready;
    logic [DATA_W-1:0] wdat;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        output cmd_valid, cmd_op, cmd_tgt, cmd_addr, cmd_len, wdat_valid, wdat, rsp_ready,
        input  cmd_ready, wdat_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tgt, cmd_addr, cmd_len, wdat_valid, wdat, rsp_ready,
        output cmd_ready, wdat_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

// File: rtl/dbg_probe_mux.sv
// rtl/dbg_probe_mux.sv - indexed selector over packed probe channels
module dbg_probe_mux #(
    parameter int NPROBE = 18,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 10
) (
    input  logic [NPROBE*DATA_W-1:0] probe_bus,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        data
);
    // Out-of-range indices read as zero.
    always_comb begin
        data = '0;
        for (int k = 0; k < NPROBE; k++) begin
            if (32'(sel) == k) data = probe_bus[k*DATA_W +: DATA_W];
        end
    end
endmodule

// File: rtl/dbg_mem_access.sv
// rtl/dbg_mem_access.sv - length-counted probe/memory transaction engine for the debug unit
module dbg_mem_access
    import dbg_pkg::*;
#(
    parameter int NPROBE = 18,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NMEM   = 3,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPROBE*DATA_W-1:0] probe_bus,
    dbg_mem_access_if.slave          bus,
    output logic [NMEM-1:0]          mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [NMEM*DATA_W-1:0]   mem_rdata,
    output logic                     cpu_hold,
    output logic                     err
);
    state_e            state;
    op_e               op;
    logic [1:0]        tgt;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  beats_left;
    logic [DATA_W-1:0] rsp_q;
    logic              err_q;
    logic [DATA_W-1:0] probe_data;
    logic              accept;
    logic              cmd_bad;
    logic              wr_beat;

    dbg_probe_mux #(
        .NPROBE (NPROBE),
        .DATA_W (DATA_W),
        .SEL_W  (ADDR_W)
    ) u_probe_mux (
        .probe_bus (probe_bus),
        .sel       (addr),
        .data      (probe_data)
    );

    always_comb begin
        cmd_bad = 1'b0;
        case (op_e'(bus.cmd_op))
            OP_PROBE_RD:          cmd_bad = 32'(bus.cmd_addr) >= NPROBE;
            OP_MEM_RD, OP_MEM_WR: cmd_bad = 32'(bus.cmd_tgt) >= NMEM;
            default:              cmd_bad = 1'b1;
        endcase
    end

    // Everything visible outside is forced quiet while rst is held.
    assign bus.cmd_ready  = !rst && (state == S_IDLE);
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign bus.wdat_ready = !rst && (state == S_WR);
    assign wr_beat        = bus.wdat_ready && bus.wdat_valid;
    assign bus.rsp_valid  = !rst && (state == S_RSP || state == S_ACK);
    assign bus.rsp_last   = bus.rsp_valid && (state == S_ACK || beats_left == '0);
    assign bus.rsp_data   = rsp_q;
    assign mem_en         = (!rst && (state == S_RD_REQ || wr_beat)) ? (NMEM'(1) << tgt) : '0;
    assign mem_we         = wr_beat;
    assign mem_addr       = addr;
    assign mem_wdata      = wr_beat ? bus.wdat : '0;
    assign cpu_hold       = !rst && (state != S_IDLE);
    assign err            = !rst && err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op         <= OP_PROBE_RD;
            tgt        <= '0;
            addr       <= '0;
            len        <= '0;
            beats_left <= '0;
            rsp_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op         <= op_e'(bus.cmd_op);
                        tgt        <= bus.cmd_tgt;
                        addr       <= bus.cmd_addr;
                        len        <= bus.cmd_len;
                        beats_left <= bus.cmd_len;
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                            rsp_q <= '0;
                            state <= S_ACK;
                        end else begin
                            case (op_e'(bus.cmd_op))
                                OP_PROBE_RD: state <= S_PROBE;
                                OP_MEM_RD:   state <= S_RD_REQ;
                                default:     state <= S_WR;
                            endcase
                        end
                    end
                end
                S_PROBE: begin
                    rsp_q <= probe_data;
                    state <= S_RSP;
                end
                S_RD_REQ: state <= S_RD_DATA;
                S_RD_DATA: begin
                    rsp_q <= mem_rdata[32'(tgt)*DATA_W +: DATA_W];
                    state <= S_RSP;
                end
                S_RSP: begin
                    if (bus.rsp_ready) begin
                        if (beats_left == '0) begin
                            state <= S_IDLE;
                        end else begin
                            beats_left <= beats_left - LEN_W'(1);
                            if (op == OP_PROBE_RD) begin
                                // Probe index wraps on the channel count, not on 2^ADDR_W.
                                addr  <= (32'(addr) == NPROBE - 1) ? '0 : addr + ADDR_W'(1);
                                state <= S_PROBE;
                            end else begin
                                addr  <= addr + ADDR_W'(1);
                                state <= S_RD_REQ;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (bus.wdat_valid) begin
                        addr <= addr + ADDR_W'(1);
                        if (beats_left == '0) begin
                            rsp_q <= DATA_W'(len) + DATA_W'(1);
                            state <= S_ACK;
                        end else begin
                            beats_left <= beats_left - LEN_W'(1);
                        end
                    end
                end
                S_ACK: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dbg_mem_access.sv
// tb/tb_dbg_mem_access.sv - self-checking bench for dbg_mem_access
module tb_dbg_mem_access;
    localparam int NPROBE = 18;
    localparam int DW     = 32;
    localparam int AW     = 10;
    localparam int NMEM   = 3;
    localparam int LW     = 8;
    localparam int TMO    = 200;

    typedef struct { logic [31:0] data; logic last; } rsp_t;
    typedef struct { logic we; logic [1:0] tgt; logic [9:0] addr; logic [31:0] wdata; } mem_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NPROBE*DW-1:0] probe_bus;
    logic [NMEM-1:0]      mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [NMEM*DW-1:0]   mem_rdata;
    logic                 cpu_hold;
    logic                 err;

    dbg_mem_access_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus ();

    dbg_mem_access #(
        .NPROBE(NPROBE), .DATA_W(DW), .ADDR_W(AW), .NMEM(NMEM), .LEN_W(LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .probe_bus (probe_bus),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold),
        .err       (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    rsp_t        exp_rsp[$];
    mem_t        exp_mem[$];
    int          exp_err = 0;
    logic        exp_hold = 1'b0;
    int          cyc_cnt = 0;
    logic [31:0] got_data[$];
    logic        got_last[$];
    int          acc_cyc[$];
    int          last_cyc[$];
    logic [31:0] ref_mem [NMEM][1024];
    logic [31:0] emu_mem [NMEM][1024];
    logic [31:0] wbuf [8];
    mem_t        cm;
    logic        nh;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Synchronous memory targets with one-cycle read latency.
    always @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NMEM; t++)
                for (int i = 0; i < 1024; i++) emu_mem[t][i] = '0;
            mem_rdata <= '0;
        end else begin
            for (int t = 0; t < NMEM; t++) begin
                if (mem_en[t]) begin
                    if (mem_we) emu_mem[t][mem_addr] = mem_wdata;
                    else        mem_rdata[t*DW +: DW] <= emu_mem[t][mem_addr];
                end
            end
        end
    end

    function automatic bit is_bad(input logic [1:0] op, input logic [1:0] tgt, input logic [9:0] addr);
        return (op == 2'd3) || (op == 2'd0 && int'(addr) >= NPROBE) || (op != 2'd0 && int'(tgt) >= NMEM);
    endfunction

    // Transaction-level model: expected response beats and memory strobes.
    task automatic model_push(input logic [1:0] op, input logic [1:0] tgt, input logic [9:0] addr, input logic [7:0] len);
        rsp_t r;
        mem_t m;
        int   a;
        if (is_bad(op, tgt, addr)) begin
            exp_err++;
            r.data = 0; r.last = 1'b1;
            exp_rsp.push_back(r);
            return;
        end
        a = int'(addr);
        for (int b = 0; b <= int'(len); b++) begin
            if (op == 2'd0) begin
                r.data = 32'(a); r.last = (b == int'(len));
                exp_rsp.push_back(r);
                a = (a + 1) % NPROBE;
            end else if (op == 2'd1) begin
                m = '{1'b0, tgt, 10'(a), 32'd0};
                exp_mem.push_back(m);
                r.data = ref_mem[tgt][a]; r.last = (b == int'(len));
                exp_rsp.push_back(r);
                a = (a + 1) % 1024;
            end else begin
                ref_mem[tgt][a] = wbuf[b];
                m = '{1'b1, tgt, 10'(a), wbuf[b]};
                exp_mem.push_back(m);
                a = (a + 1) % 1024;
            end
        end
        if (op == 2'd2) begin
            r.data = 32'(int'(len) + 1); r.last = 1'b1;
            exp_rsp.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        cyc_cnt++;
        if (rst) begin
            exp_rsp.delete(); exp_mem.delete();
            exp_err = 0; exp_hold = 1'b0;
            chk("rst_quiet", {bus.cmd_ready, bus.rsp_valid, mem_en, cpu_hold, err}, '0);
        end else begin
            chk("cpu_hold", cpu_hold, exp_hold);
            chk("cmd_ready", bus.cmd_ready, !exp_hold);
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) chk("rsp_extra", bus.rsp_valid, 1'b0);
                else begin
                    chk("rsp_data", bus.rsp_data, exp_rsp[0].data);
                    chk("rsp_last", bus.rsp_last, exp_rsp[0].last);
                    if (bus.rsp_ready) begin
                        got_data.push_back(bus.rsp_data);
                        got_last.push_back(bus.rsp_last);
                        void'(exp_rsp.pop_front());
                    end
                end
            end
            if (mem_en != '0) begin
                if (exp_mem.size() == 0) chk("mem_extra", mem_en, '0);
                else begin
                    cm = exp_mem.pop_front();
                    chk("mem_en", mem_en, 3'b001 << cm.tgt);
                    chk("mem_we", mem_we, cm.we);
                    chk("mem_addr", mem_addr, cm.addr);
                    if (cm.we) chk("mem_wdata", mem_wdata, cm.wdata);
                end
            end else begin
                chk("mem_we_idle", mem_we, 1'b0);
            end
            if (err) begin
                chk("err_pulse", err, exp_err != 0);
                if (exp_err != 0) exp_err--;
            end
            nh = exp_hold;
            if (bus.cmd_valid && bus.cmd_ready) begin
                nh = 1'b1;
                acc_cyc.push_back(cyc_cnt);
            end
            if (bus.rsp_valid && bus.rsp_ready && bus.rsp_last) begin
                nh = 1'b0;
                last_cyc.push_back(cyc_cnt);
            end
            exp_hold = nh;
        end
    end

    task automatic drive_cmd(input logic [1:0] op, input logic [1:0] tgt, input logic [9:0] addr, input logic [7:0] len);
        bit acc = 0;
        int cyc = 0;
        bus.cmd_op = op; bus.cmd_tgt = tgt; bus.cmd_addr = addr; bus.cmd_len = len;
        bus.cmd_valid = 1'b1;
        while (!acc && cyc < TMO) begin
            @(negedge clk); acc = bus.cmd_ready;
            @(posedge clk); #1; cyc++;
        end
        bus.cmd_valid = 1'b0;
        chk("cmd_accept", acc, 1'b1);
    endtask

    task automatic drive_wdat(input int n, input int gap);
        bit hs;
        int cyc;
        for (int i = 0; i < n; i++) begin
            bus.wdat_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
            bus.wdat = wbuf[i]; bus.wdat_valid = 1'b1;
            hs = 0; cyc = 0;
            while (!hs && cyc < TMO) begin
                @(negedge clk); hs = bus.wdat_ready;
                @(posedge clk); #1; cyc++;
            end
            chk("wdat_accept", hs, 1'b1);
        end
        bus.wdat_valid = 1'b0; bus.wdat = '0;
    endtask

    task automatic drive_rsp(input int n, input int stall_beat, input int stall_len);
        int b = 0, st = 0, cyc = 0;
        while (b < n && cyc < TMO) begin
            bus.rsp_ready = !(b == stall_beat && st < stall_len);
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (bus.rsp_ready) b++;
                else st++;
            end
            @(posedge clk); #1; cyc++;
        end
        bus.rsp_ready = 1'b0;
        chk("rsp_beats", b, n);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] tgt, input logic [9:0] addr,
                           input logic [7:0] len, input int gap, input int stall_beat, input int stall_len);
        bit bad;
        int nrsp;
        got_data.delete(); got_last.delete();
        model_push(op, tgt, addr, len);
        bad  = is_bad(op, tgt, addr);
        nrsp = (bad || op == 2'd2) ? 1 : int'(len) + 1;
        fork
            drive_cmd(op, tgt, addr, len);
            if (!bad && op == 2'd2) drive_wdat(int'(len) + 1, gap);
            drive_rsp(nrsp, stall_beat, stall_len);
        join
        @(negedge clk);
        chk("drained", exp_rsp.size() + exp_mem.size() + exp_err, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit b2b_ok;
        int cyc;
        rst = 1'b1;
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_tgt = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.wdat_valid = 0; bus.wdat = 0; bus.rsp_ready = 0;
        for (int k = 0; k < NPROBE; k++) probe_bus[k*DW +: DW] = 32'(k);
        for (int t = 0; t < NMEM; t++)
            for (int i = 0; i < 1024; i++) ref_mem[t][i] = '0;

        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1'b0);
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        chk("reset_mem_en", mem_en, 3'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of a stalled MEM_RD burst.
        model_push(2'd1, 2'd1, 10'd0, 8'd3);
        drive_cmd(2'd1, 2'd1, 10'd0, 8'd3);
        repeat (5) @(posedge clk);
        #1; rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_cpu_hold", cpu_hold, 1'b0);
        chk("midrst_mem_en", mem_en, 3'd0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Probe burst wrapping from channel 17 to 0.
        run_cmd(2'd0, 2'd0, 10'd16, 8'd3, 0, -1, 0);
        chk("probe_n", got_data.size(), 4);
        if (got_data.size() == 4) begin
            chk("probe_b0", got_data[0], 32'd16);
            chk("probe_b1", got_data[1], 32'd17);
            chk("probe_b2", got_data[2], 32'd0);
            chk("probe_b3", got_data[3], 32'd1);
            chk("probe_last", {got_last[0], got_last[1], got_last[2], got_last[3]}, 4'b0001);
        end

        // Write burst across the address wrap, with gaps between beats.
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
        run_cmd(2'd2, 2'd1, 10'h3FE, 8'd2, 2, -1, 0);
        chk("wr_ack_n", got_data.size(), 1);
        if (got_data.size() == 1) begin
            chk("wr_ack_data", got_data[0], 32'd3);
            chk("wr_ack_last", got_last[0], 1'b1);
        end
        chk("dm_3fe", emu_mem[1][10'h3FE], 32'hA);
        chk("dm_3ff", emu_mem[1][10'h3FF], 32'hB);
        chk("dm_000", emu_mem[1][10'h000], 32'hC);

        // Read back with a 5-cycle response stall on beat 2.
        run_cmd(2'd1, 2'd1, 10'h3FE, 8'd2, 0, 1, 5);
        chk("rd_n", got_data.size(), 3);
        if (got_data.size() == 3) begin
            chk("rd_b0", got_data[0], 32'hA);
            chk("rd_b1", got_data[1], 32'hB);
            chk("rd_b2", got_data[2], 32'hC);
        end

        // Illegal commands.
        run_cmd(2'd3, 2'd0, 10'd0, 8'd0, 0, -1, 0);
        chk("ill_op_rsp", (got_data.size() == 1) ? {got_last[0], got_data[0]} : 33'h1_FFFF_FFFF, {1'b1, 32'd0});
        run_cmd(2'd1, 2'd3, 10'd5, 8'd2, 0, -1, 0);
        chk("ill_tgt_rsp", (got_data.size() == 1) ? {got_last[0], got_data[0]} : 33'h1_FFFF_FFFF, {1'b1, 32'd0});
        run_cmd(2'd0, 2'd0, 10'd18, 8'd0, 0, -1, 0);
        chk("ill_probe_rsp", (got_data.size() == 1) ? {got_last[0], got_data[0]} : 33'h1_FFFF_FFFF, {1'b1, 32'd0});

        // Seed RF[7], then two back-to-back single reads with cmd_valid held.
        wbuf[0] = 32'h55;
        run_cmd(2'd2, 2'd2, 10'd7, 8'd0, 0, -1, 0);
        got_data.delete(); got_last.delete(); acc_cyc.delete(); last_cyc.delete();
        model_push(2'd1, 2'd1, 10'h3FF, 8'd0);
        model_push(2'd1, 2'd2, 10'd7, 8'd0);
        fork
            begin
                bus.cmd_op = 2'd1; bus.cmd_tgt = 2'd1; bus.cmd_addr = 10'h3FF; bus.cmd_len = 8'd0;
                bus.cmd_valid = 1'b1;
                for (int n = 0; n < 2; n++) begin
                    b2b_ok = 0; cyc = 0;
                    while (!b2b_ok && cyc < TMO) begin
                        @(negedge clk); b2b_ok = bus.cmd_ready;
                        @(posedge clk); #1; cyc++;
                    end
                    chk("b2b_accept", b2b_ok, 1'b1);
                    bus.cmd_tgt = 2'd2; bus.cmd_addr = 10'd7;
                end
                bus.cmd_valid = 1'b0;
            end
            drive_rsp(2, -1, 0);
        join
        @(negedge clk);
        chk("b2b_drained", exp_rsp.size() + exp_mem.size(), 0);
        if (acc_cyc.size() == 2 && last_cyc.size() == 2)
            chk("b2b_gap", acc_cyc[1] - last_cyc[0], 1);
        else
            chk("b2b_events", {acc_cyc.size(), last_cyc.size()}, {32'd2, 32'd2});
        if (got_data.size() == 2) begin
            chk("b2b_d0", got_data[0], 32'hB);
            chk("b2b_d1", got_data[1], 32'h55);
        end else begin
            chk("b2b_n", got_data.size(), 2);
        end
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
